// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Op codes match the pipeline's 2-bit muldiv op field.
// State encoding is 3 bits so the FSM register stays small.
package muldiv_sequencer_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_sequencer_twos_negate.sv
// Two's-complement negate: invert plus one.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module twos_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_neg
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign o_neg = ~i_val + ONE;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit: radix-2 shift-add multiply and restoring divide, plus MTHI/MTLO.
// Latency: 34 cycles from accepted start to done, for every op.
// Backpressure: start and HI/LO writes are ignored while busy; no queuing.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a_raw, r_b_raw;
  logic [WIDTH-1:0]   r_mcand;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_sreg;         // multiplier / quotient shift register
  logic [WIDTH:0]     r_acc;          // product high part / partial remainder
  logic               r_neg_res, r_neg_rem, r_dbz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_idle_like, w_accept, w_signed;
  logic [WIDTH-1:0]   w_a_neg, w_b_neg, w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_msum, w_madd, w_dshift, w_ddiff;
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;
  logic [WIDTH-1:0]   w_quot_neg, w_rem_neg;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept    = start && w_idle_like;
  assign w_signed    = r_op[0];

  twos_negate #(.W(WIDTH)) u_neg_a (.i_val(r_a_raw), .o_neg(w_a_neg));
  twos_negate #(.W(WIDTH)) u_neg_b (.i_val(r_b_raw), .o_neg(w_b_neg));

  assign w_a_mag = (w_signed && r_a_raw[WIDTH-1]) ? w_a_neg : r_a_raw;
  assign w_b_mag = (w_signed && r_b_raw[WIDTH-1]) ? w_b_neg : r_b_raw;

  // One iteration step for each loop flavour
  assign w_msum   = r_acc + {1'b0, r_mcand};
  assign w_madd   = r_sreg[0] ? w_msum : r_acc;
  assign w_dshift = {r_acc[WIDTH-1:0], r_sreg[WIDTH-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_mcand};

  assign w_prod = {r_acc[WIDTH-1:0], r_sreg};
  twos_negate #(.W(2*WIDTH)) u_neg_prod (.i_val(w_prod), .o_neg(w_prod_neg));
  twos_negate #(.W(WIDTH)) u_neg_quot (.i_val(r_sreg), .o_neg(w_quot_neg));
  twos_negate #(.W(WIDTH)) u_neg_rem (.i_val(r_acc[WIDTH-1:0]), .o_neg(w_rem_neg));

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state: DONE can chain straight into PREP for back-to-back ops
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_PREP;
      ST_PREP:  w_next = ST_ITER;
      ST_ITER:  if (r_cnt == LAST_ITER) w_next = ST_FIXUP;
      ST_FIXUP: w_next = ST_DONE;
      ST_DONE:  w_next = start ? ST_PREP : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (r_state)
      ST_PREP, ST_ITER, ST_FIXUP: busy = 1'b1;
      ST_DONE: begin
        done        = 1'b1;
        div_by_zero = r_dbz;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, iteration, sign fixup and HI/LO writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_op      <= OP_MULTU;
      r_a_raw   <= '0;
      r_b_raw   <= '0;
      r_mcand   <= '0;
      r_sreg    <= '0;
      r_acc     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            // a start in the same cycle as a write wins; the write is dropped
            r_op    <= op;
            r_a_raw <= operand_a;
            r_b_raw <= operand_b;
          end else begin
            if (hi_write) r_hi <= write_data;
            if (lo_write) r_lo <= write_data;
          end
        end
        ST_PREP: begin
          r_cnt     <= '0;
          r_acc     <= '0;
          r_neg_res <= w_signed && (r_a_raw[WIDTH-1] ^ r_b_raw[WIDTH-1]);
          r_neg_rem <= w_signed && r_a_raw[WIDTH-1];
          r_dbz     <= r_op[1] && (r_b_raw == '0);
          if (r_op[1]) begin
            r_sreg  <= w_a_mag;
            r_mcand <= w_b_mag;
          end else begin
            r_sreg  <= w_b_mag;
            r_mcand <= w_a_mag;
          end
        end
        ST_ITER: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_op[1]) begin
            r_acc  <= w_ddiff[WIDTH] ? w_dshift : w_ddiff;
            r_sreg <= {r_sreg[WIDTH-2:0], ~w_ddiff[WIDTH]};
          end else begin
            r_acc  <= {1'b0, w_madd[WIDTH:1]};
            r_sreg <= {w_madd[0], r_sreg[WIDTH-1:1]};
          end
        end
        ST_FIXUP: begin
          if (r_op[1]) begin
            if (r_dbz) begin
              // divide by zero: LO saturates, HI returns the untouched dividend
              r_lo <= '1;
              r_hi <= r_a_raw;
            end else begin
              r_lo <= r_neg_res ? w_quot_neg : r_sreg;
              r_hi <= r_neg_rem ? w_rem_neg : r_acc[WIDTH-1:0];
            end
          end else begin
            {r_hi, r_lo} <= r_neg_res ? w_prod_neg : w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, busy window,
// done pulse width, and the start/write hazard rules.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clock, reset, start, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, write_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hi_write(hi_write), .lo_write(lo_write), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a start at the current (post-negedge) time and follow it to done.
  // hw: also raise hi_write with the start; inject: poke start and lo_write mid-run.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit hw, input bit inject,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz);
    logic [31:0] hi_before;
    int n, busy_cnt;
    bit seen;
    hi_before  = hi;
    start      = 1'b1;
    op         = o;
    operand_a  = a;
    operand_b  = b;
    hi_write   = hw;
    write_data = 32'h0000_DEAD;
    n = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        start    = 1'b0;
        hi_write = 1'b0;
        if (hw) chk({tag, "_hi_held"}, hi, hi_before);
      end
      if (inject && n == 10) begin
        start = 1'b1; op = OP_DIVU; operand_a = 32'd1; operand_b = 32'd1;
      end
      if (inject && n == 11) start = 1'b0;
      if (inject && n == 12) begin lo_write = 1'b1; write_data = 32'h0000_1234; end
      if (inject && n == 13) lo_write = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'd35);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd34);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_MULTU; operand_a = '0; operand_b = '0;
    hi_write = 1'b0; lo_write = 1'b0; write_data = '0;
    @(negedge clock); @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // MTHI / MTLO while idle
    hi_write = 1'b1; write_data = 32'hCAFE_0001;
    @(negedge clock);
    hi_write = 1'b0; lo_write = 1'b1; write_data = 32'h0BAD_0002;
    chk("mthi", hi, 32'hCAFE_0001);
    @(negedge clock);
    lo_write = 1'b0;
    chk("mtlo", lo, 32'h0BAD_0002);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clock);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 1'b0);
    // back-to-back: start issued in the DONE cycle
    run_op("div_b2b", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge clock);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
           32'h0000_0000, 32'h8000_0000, 1'b0);
    @(negedge clock);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 0, 0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    @(negedge clock);
    run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF8, 32'd0, 0, 0,
           32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
    @(negedge clock);
    chk("dbz_clears", 32'(div_by_zero), 32'd0);

    // start and lo_write while busy are both ignored
    run_op("busy_hazard", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 1,
           32'h0000_0001, 32'h0000_0000, 1'b0);
    @(negedge clock);
    // start with hi_write in the same cycle drops the write
    run_op("start_hw", OP_DIVU, 32'd9, 32'd4, 1, 0, 32'd1, 32'd2, 1'b0);
    @(negedge clock);

    // reset ten cycles into a DIV aborts it
    start = 1'b1; op = OP_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_op("multu_after_rst", OP_MULTU, 32'd3, 32'd4, 0, 0, 32'd0, 32'd12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
